// File: rtl/bp_nonsynth_mem_resp_monitor.sv
// bp_nonsynth_mem_resp_monitor: passive BedRock mem cmd/resp ordering checker with a sticky first-error code.
// Optional watchdog (code 6) is enabled by defining BP_MEM_MONITOR_TIMEOUT_EN.
module bp_nonsynth_mem_resp_monitor #(
  parameter int els_p         = 8,
  parameter int paddr_width_p = 40,
  parameter int timeout_p     = 1024
)(
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       mem_cmd_v_i,
  input  logic                       mem_cmd_ready_and_i,
  input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
  input  logic [3:0]                 mem_cmd_msg_type_i,
  input  logic [2:0]                 mem_cmd_size_i,
  input  logic                       mem_resp_v_i,
  input  logic                       mem_resp_ready_and_i,
  input  logic [paddr_width_p-1:0]   mem_resp_addr_i,
  input  logic [3:0]                 mem_resp_msg_type_i,
  input  logic [2:0]                 mem_resp_size_i,
  output logic [$clog2(els_p+1)-1:0] outstanding_o,
  output logic                       error_o,
  output logic [2:0]                 error_code_o
);
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);
  typedef struct packed {
    logic [paddr_width_p-1:0] addr;
    logic [3:0]               msg;
    logic [2:0]               size;
  } entry_t;
  typedef enum logic {e_ok, e_error} state_e;
  entry_t             mem_q [els_p];
  entry_t             head;
  logic [ptr_w-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [2:0]         code_q, code_d, err;
  logic               push, pop, full, empty, do_push, do_pop;
  logic               overflow, underflow, mis_a, mis_m, mis_s, timeout;
  assign push      = mem_cmd_v_i & mem_cmd_ready_and_i;
  assign pop       = mem_resp_v_i & mem_resp_ready_and_i;
  assign full      = cnt_q == cnt_w'(els_p);
  assign empty     = cnt_q == '0;
  assign do_pop    = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push   = push & (~full | do_pop);
  assign overflow  = push & full & ~pop;
  assign underflow = pop & empty;
  assign head      = mem_q[rptr_q];
  assign mis_a     = do_pop & (head.addr != mem_resp_addr_i);
  assign mis_m     = do_pop & (head.msg  != mem_resp_msg_type_i);
  assign mis_s     = do_pop & (head.size != mem_resp_size_i);
  assign err       = overflow  ? 3'd1 :
                     underflow ? 3'd2 :
                     mis_a     ? 3'd3 :
                     mis_m     ? 3'd4 :
                     mis_s     ? 3'd5 :
                     timeout   ? 3'd6 : 3'd0;
  assign wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;
  assign cnt_d  = cnt_q + cnt_w'(do_push) - cnt_w'(do_pop);
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wptr_q] <= '{mem_cmd_addr_i, mem_cmd_msg_type_i, mem_cmd_size_i};
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
`ifdef BP_MEM_MONITOR_TIMEOUT_EN
  localparam int wd_w = $clog2(timeout_p+1);
  logic [wd_w-1:0] wd_q, wd_d;
  assign timeout = wd_q == wd_w'(timeout_p);
  assign wd_d    = (pop | empty) ? '0 : timeout ? wd_q : wd_q + 1'b1;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) wd_q <= '0;
    else         wd_q <= wd_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = (state_q == e_ok && err != 3'd0) ? e_error : state_q;
    code_d  = (state_q == e_ok && err != 3'd0) ? err : code_q;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= e_ok;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  assign outstanding_o = cnt_q;
  assign error_o       = state_q == e_error;
  assign error_code_o  = code_q;
endmodule

// File: tb/tb_bp_nonsynth_mem_resp_monitor.sv
// tb_bp_nonsynth_mem_resp_monitor: directed and randomized checks against a queue-based reference model.
module tb_bp_nonsynth_mem_resp_monitor;
  localparam int ELS = 8;
  localparam int TO  = 16;
  typedef struct packed {
    logic [39:0] a;
    logic [3:0]  m;
    logic [2:0]  s;
  } ent_t;
  logic        clk_i = 0, reset_i = 1;
  logic        mem_cmd_v_i = 0, mem_cmd_ready_and_i = 0, mem_resp_v_i = 0, mem_resp_ready_and_i = 0;
  logic [39:0] mem_cmd_addr_i = '0, mem_resp_addr_i = '0;
  logic [3:0]  mem_cmd_msg_type_i = '0, mem_resp_msg_type_i = '0;
  logic [2:0]  mem_cmd_size_i = '0, mem_resp_size_i = '0;
  logic [3:0]  outstanding_o;
  logic        error_o;
  logic [2:0]  error_code_o;
  int checks = 0, errors = 0;
  ent_t q[$];
  bit   m_err;
  int   m_code, wd;
  bp_nonsynth_mem_resp_monitor #(.els_p(ELS), .paddr_width_p(40), .timeout_p(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
    .mem_cmd_addr_i(mem_cmd_addr_i), .mem_cmd_msg_type_i(mem_cmd_msg_type_i), .mem_cmd_size_i(mem_cmd_size_i),
    .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_and_i(mem_resp_ready_and_i),
    .mem_resp_addr_i(mem_resp_addr_i), .mem_resp_msg_type_i(mem_resp_msg_type_i), .mem_resp_size_i(mem_resp_size_i),
    .outstanding_o(outstanding_o), .error_o(error_o), .error_code_o(error_code_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".outstanding"}, 64'(outstanding_o), 64'(q.size()));
    chk({tag, ".error"},       64'(error_o),       64'(m_err));
    chk({tag, ".code"},        64'(error_code_o),  64'(m_code));
  endtask
  task automatic model_clear();
    q.delete();
    m_err = 0;
    m_code = 0;
    wd = 0;
  endtask
  // One clock: drive, let the edge happen, advance the model, compare 1 time unit later
  task automatic cyc(input string tag, input bit cv, input bit cr, input ent_t c, input bit rv, input bit rr, input ent_t r);
    int code, cnt0;
    ent_t h;
    mem_cmd_v_i = cv; mem_cmd_ready_and_i = cr;
    {mem_cmd_addr_i, mem_cmd_msg_type_i, mem_cmd_size_i} = c;
    mem_resp_v_i = rv; mem_resp_ready_and_i = rr;
    {mem_resp_addr_i, mem_resp_msg_type_i, mem_resp_size_i} = r;
    @(posedge clk_i);
    code = 0;
    cnt0 = q.size();
`ifdef BP_MEM_MONITOR_TIMEOUT_EN
    if (wd == TO) code = 6;
    wd = ((rv && rr) || cnt0 == 0) ? 0 : (wd < TO ? wd + 1 : wd);
`endif
    if (rv && rr) begin
      if (q.size() == 0) code = 2;
      else begin
        h = q.pop_front();
        code = (h.a != r.a) ? 3 : (h.m != r.m) ? 4 : (h.s != r.s) ? 5 : code;
      end
    end
    if (cv && cr) begin
      if (q.size() == ELS) code = 1;
      else q.push_back(c);
    end
    if (!m_err && code != 0) begin
      m_err = 1;
      m_code = code;
    end
    #1;
    chk_all(tag);
  endtask
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, '0, 0, 0, '0);
  endtask
  task automatic do_reset();
    #2 reset_i = 1;
    #1;
    model_clear();
    chk("rst.async_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst.async_error",       64'(error_o),       64'd0);
    chk("rst.async_code",        64'(error_code_o),  64'd0);
    mem_cmd_v_i = 1; mem_cmd_ready_and_i = 1;
    mem_resp_v_i = 0; mem_resp_ready_and_i = 0;
    @(posedge clk_i);
    #1;
    chk("rst.ignore_cmd", 64'(outstanding_o), 64'd0);
    mem_cmd_v_i = 0; mem_cmd_ready_and_i = 0;
    reset_i = 0;
  endtask
  function automatic ent_t mk(input logic [39:0] a, input logic [3:0] m, input logic [2:0] s);
    return '{a, m, s};
  endfunction
  function automatic ent_t rnd_ent();
    return '{{8'h00, $urandom()}, 4'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
  endfunction
  initial begin
    ent_t c, r;
    model_clear();
    #3;
    chk("reset.outstanding", 64'(outstanding_o), 64'd0);
    chk("reset.error",       64'(error_o),       64'd0);
    chk("reset.code",        64'(error_code_o),  64'd0);
    @(posedge clk_i);
    #1 reset_i = 0;
    // three in-order commands and matching responses
    for (int i = 0; i < 3; i++) cyc("inorder.cmd", 1, 1, mk(40'h8000_0000 + 40'(i * 'h40), 4'd1, 3'd3), 0, 0, '0);
    chk("inorder.peak", 64'(outstanding_o), 64'd3);
    for (int i = 0; i < 3; i++) cyc("inorder.resp", 0, 0, '0, 1, 1, mk(40'h8000_0000 + 40'(i * 'h40), 4'd1, 3'd3));
    chk("inorder.final_count", 64'(outstanding_o), 64'd0);
    chk("inorder.final_err",   64'(error_o),       64'd0);
    // valid without ready is not a handshake
    cyc("noready", 1, 0, mk(40'h5, 4'd0, 3'd0), 1, 0, mk(40'h5, 4'd0, 3'd0));
    // underflow, then a later mismatch keeps code 2
    do_reset();
    cyc("underflow", 0, 0, '0, 1, 1, mk(40'h0, 4'd0, 3'd0));
    chk("underflow.code", 64'(error_code_o), 64'd2);
    cyc("underflow.cmd", 1, 1, mk(40'h100, 4'd2, 3'd1), 0, 0, '0);
    cyc("underflow.mis", 0, 0, '0, 1, 1, mk(40'h200, 4'd2, 3'd1));
    chk("underflow.sticky", 64'(error_code_o), 64'd2);
    // underflow with same-cycle push: push still enqueued
    do_reset();
    cyc("underflow_push", 1, 1, mk(40'h40, 4'd1, 3'd2), 1, 1, mk(40'h40, 4'd1, 3'd2));
    chk("underflow_push.count", 64'(outstanding_o), 64'd1);
    // address mismatch outranks size mismatch
    do_reset();
    cyc("addr.cmd",  1, 1, mk(40'h1000, 4'd0, 3'd3), 0, 0, '0);
    cyc("addr.resp", 0, 0, '0, 1, 1, mk(40'h1040, 4'd0, 3'd2));
    chk("addr.code",  64'(error_code_o),  64'd3);
    chk("addr.count", 64'(outstanding_o), 64'd0);
    // msg_type and size mismatches
    do_reset();
    cyc("msg.cmd",  1, 1, mk(40'h20, 4'd3, 3'd1), 0, 0, '0);
    cyc("msg.resp", 0, 0, '0, 1, 1, mk(40'h20, 4'd4, 3'd2));
    chk("msg.code", 64'(error_code_o), 64'd4);
    do_reset();
    cyc("size.cmd",  1, 1, mk(40'h20, 4'd3, 3'd1), 0, 0, '0);
    cyc("size.resp", 0, 0, '0, 1, 1, mk(40'h20, 4'd3, 3'd2));
    chk("size.code", 64'(error_code_o), 64'd5);
    // full FIFO: simultaneous push+pop is legal, lone push overflows
    do_reset();
    for (int i = 0; i < ELS; i++) cyc("fill", 1, 1, mk(40'(i), 4'd1, 3'd0), 0, 0, '0);
    chk("fill.count", 64'(outstanding_o), 64'(ELS));
    cyc("full.pushpop", 1, 1, mk(40'h99, 4'd1, 3'd0), 1, 1, mk(40'h0, 4'd1, 3'd0));
    chk("full.pushpop_err",   64'(error_o),       64'd0);
    chk("full.pushpop_count", 64'(outstanding_o), 64'(ELS));
    cyc("overflow", 1, 1, mk(40'hAA, 4'd1, 3'd0), 0, 0, '0);
    chk("overflow.code",  64'(error_code_o),  64'd1);
    chk("overflow.count", 64'(outstanding_o), 64'(ELS));
    // drain checks wrap of pointers and that the overflowed entry was dropped
    for (int i = 1; i < ELS; i++) cyc("drain", 0, 0, '0, 1, 1, mk(40'(i), 4'd1, 3'd0));
    cyc("drain.last", 0, 0, '0, 1, 1, mk(40'h99, 4'd1, 3'd0));
    chk("drain.count", 64'(outstanding_o), 64'd0);
    // watchdog
    do_reset();
    cyc("wd.cmd", 1, 1, mk(40'h300, 4'd0, 3'd0), 0, 0, '0);
    idle("wd.idle", 3 * TO);
`ifdef BP_MEM_MONITOR_TIMEOUT_EN
    chk("wd.code", 64'(error_code_o), 64'd6);
`else
    chk("wd.code", 64'(error_code_o), 64'd0);
`endif
    // randomized segments; responses mostly echo the expected head
    for (int seg = 0; seg < 12; seg++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        c = rnd_ent();
        r = (q.size() != 0 && $urandom_range(0, 15) != 0) ? q[0] : rnd_ent();
        cyc("random", $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, c,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, r);
      end
    end
    // mid-stream reset with 5 outstanding and a latched error
    do_reset();
    for (int i = 0; i < 6; i++) cyc("mid.cmd", 1, 1, mk(40'h400 + 40'(i), 4'd2, 3'd2), 0, 0, '0);
    cyc("mid.mis", 0, 0, '0, 1, 1, mk(40'h7FF, 4'd2, 3'd2));
    chk("mid.count", 64'(outstanding_o), 64'd5);
    chk("mid.err",   64'(error_o),       64'd1);
    do_reset();
    cyc("post.cmd",  1, 1, mk(40'h8000_0000, 4'd1, 3'd3), 0, 0, '0);
    cyc("post.resp", 0, 0, '0, 1, 1, mk(40'h8000_0000, 4'd1, 3'd3));
    chk("post.count", 64'(outstanding_o), 64'd0);
    chk("post.err",   64'(error_o),       64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
